// File: rtl/key_matrix_scanner_if.sv
// Key event bus from the matrix scanner to the tone generator and display logic.
// master drives the events, slave consumes them.
interface key_matrix_scanner_if #(
    parameter int CODE_W = 4
);
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_release;
    logic              key_down;

    modport master (output key_code, key_valid, key_release, key_down);
    modport slave  (input  key_code, key_valid, key_release, key_down);
endinterface

// File: rtl/key_matrix_scanner.sv
// Row-multiplexed piano key matrix scanner with whole-frame debounce and press/release events.
// Optional feature: define KEYSCAN_GHOST_REJECT_EN to discard frames with two or more pressed keys.
module key_matrix_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ROWS-1:0]      row_n,
    input  logic [COLS-1:0]      col_n,
    key_matrix_scanner_if.master evt
);
    localparam int KEYS   = ROWS * COLS;
    localparam int CODE_W = $clog2(KEYS);
    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W  = 4;

    typedef enum logic {IDLE, HELD} state_t;

    state_t                    state, state_nxt;
    logic [COLS-1:0]           col_meta, col_sync;
    logic [TICK_W-1:0]         tick;
    logic [ROW_W-1:0]          row_idx;
    logic [ROWS-1:0][COLS-1:0] frame_q;
    logic [ROWS-1:0][COLS-1:0] frame_full;
    logic [KEYS-1:0]           pressed;
    logic                      slot_end, frame_end, frame_use;
    logic                      any_hit;
    logic [CODE_W-1:0]         low_code;
    logic                      cand_none;
    logic [CODE_W-1:0]         cand_code;
    logic                      prev_none;
    logic [CODE_W-1:0]         prev_code;
    logic [CNT_W-1:0]          match_cnt, cnt_next;
    logic                      same, saturated, stable;
    logic [CODE_W-1:0]         key_code_q, code_nxt;
    logic                      valid_q, valid_nxt;
    logic                      release_q, release_nxt;

    // Columns idle high, so the synchronizer resets to "nothing pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    assign slot_end  = (tick == TICK_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (row_idx == ROW_W'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick    <= '0;
            row_idx <= '0;
            frame_q <= '0;
        end else if (slot_end) begin
            tick             <= '0;
            frame_q[row_idx] <= ~col_sync;
            row_idx          <= (row_idx == ROW_W'(ROWS - 1)) ? '0 : row_idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    always_comb begin
        row_n          = '1;
        row_n[row_idx] = 1'b0;
    end

    // The last row is classified straight from the synchronizer so events land one cycle after frame end.
    always_comb begin
        frame_full          = frame_q;
        frame_full[row_idx] = ~col_sync;
    end

    assign pressed = frame_full;

`ifdef KEYSCAN_GHOST_REJECT_EN
    logic multi_hit;

    always_comb begin
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        low_code  = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (pressed[i]) begin
                if (any_hit) begin
                    multi_hit = 1'b1;
                end else begin
                    any_hit  = 1'b1;
                    low_code = CODE_W'(i);
                end
            end
        end
    end

    assign frame_use = frame_end && !multi_hit;
`else
    always_comb begin
        any_hit  = 1'b0;
        low_code = '0;
        for (int i = 0; i < KEYS; i++) begin
            if (pressed[i] && !any_hit) begin
                any_hit  = 1'b1;
                low_code = CODE_W'(i);
            end
        end
    end

    assign frame_use = frame_end;
`endif

    assign cand_none = !any_hit;
    assign cand_code = low_code;

    // A saturated count on a repeated candidate must not re-fire the stable result.
    always_comb begin
        same      = (cand_none == prev_none) && (cand_none || (cand_code == prev_code));
        saturated = same && (match_cnt == CNT_W'(DEBOUNCE));
        if (!same)          cnt_next = CNT_W'(1);
        else if (saturated) cnt_next = match_cnt;
        else                cnt_next = match_cnt + 1'b1;
        stable    = frame_use && !saturated && (cnt_next == CNT_W'(DEBOUNCE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_none <= 1'b1;
            prev_code <= '0;
            match_cnt <= '0;
        end else if (frame_use) begin
            prev_none <= cand_none;
            prev_code <= cand_code;
            match_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_code_q <= '0;
            valid_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            key_code_q <= code_nxt;
            valid_q    <= valid_nxt;
            release_q  <= release_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (stable) begin
            case (state)
                IDLE:    if (!cand_none) state_nxt = HELD;
                HELD:    if (cand_none)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_nxt   = 1'b0;
        release_nxt = 1'b0;
        code_nxt    = key_code_q;
        if (stable) begin
            case (state)
                IDLE: begin
                    if (!cand_none) begin
                        valid_nxt = 1'b1;
                        code_nxt  = cand_code;
                    end
                end
                HELD: begin
                    if (cand_none) begin
                        release_nxt = 1'b1;
                    end else if (cand_code != key_code_q) begin
                        valid_nxt = 1'b1;
                        code_nxt  = cand_code;
                    end
                end
                default: ;
            endcase
        end
    end

    assign evt.key_code    = key_code_q;
    assign evt.key_valid   = valid_q;
    assign evt.key_release = release_q;
    assign evt.key_down    = (state == HELD);
endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: a contact-set matrix model drives the DUT while a
// frame-level reference model predicts every output cycle by cycle.
module tb_key_matrix_scanner;
    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;
    localparam int KEYS     = ROWS * COLS;
    localparam int FRAME    = ROWS * SCAN_DIV;
`ifdef KEYSCAN_GHOST_REJECT_EN
    localparam int CHORD_VALIDS = 0;
    localparam int CHORD_CODE   = 12;
`else
    localparam int CHORD_VALIDS = 1;
    localparam int CHORD_CODE   = 0;
`endif

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col_n;
    logic [KEYS-1:0] keys  = '0;

    int checks   = 0;
    int failures = 0;

    key_matrix_scanner_if #(.CODE_W(4)) evt();

    key_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .row_n (row_n),
        .col_n (col_n),
        .evt   (evt)
    );

    always #5 clk = ~clk;

    // A closed contact pulls its column low while its row is driven low.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_n[r] && keys[r*COLS + c]) col_n[c] = 1'b0;
    end

    int              mk;
    logic [COLS-1:0] m_frame [ROWS];
    int              m_prev, m_cnt, m_code;
    bit              m_held, exp_valid, exp_release;

    int n_valid, n_release, first_code, last_code, last_at;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mk          = 0;
        m_prev      = -1;
        m_cnt       = 0;
        m_code      = 0;
        m_held      = 1'b0;
        exp_valid   = 1'b0;
        exp_release = 1'b0;
        for (int r = 0; r < ROWS; r++) m_frame[r] = '0;
    endfunction

    function automatic void modelFrame();
        logic [KEYS-1:0] fr;
        int  n, low, cand;
        bit  reached;
        for (int r = 0; r < ROWS; r++) fr[r*COLS +: COLS] = m_frame[r];
        n   = $countones(fr);
        low = -1;
        for (int i = KEYS - 1; i >= 0; i--) if (fr[i]) low = i;
`ifdef KEYSCAN_GHOST_REJECT_EN
        if (n >= 2) return;
`endif
        cand    = (n == 0) ? -1 : low;
        reached = 1'b0;
        if (cand == m_prev) begin
            if (m_cnt < DEBOUNCE) begin
                m_cnt++;
                reached = (m_cnt == DEBOUNCE);
            end
        end else begin
            m_cnt   = 1;
            reached = (DEBOUNCE == 1);
        end
        m_prev = cand;
        if (reached) begin
            if (cand >= 0 && (!m_held || cand != m_code)) begin
                exp_valid = 1'b1;
                m_code    = cand;
                m_held    = 1'b1;
            end else if (cand < 0 && m_held) begin
                exp_release = 1'b1;
                m_held      = 1'b0;
            end
        end
    endfunction

    // Each row is seen as the contacts present two edges before its slot-end edge.
    function automatic void modelEdge();
        int r;
        exp_valid   = 1'b0;
        exp_release = 1'b0;
        r = (mk / SCAN_DIV) % ROWS;
        if (mk % SCAN_DIV == SCAN_DIV - 3) m_frame[r] = keys[r*COLS +: COLS];
        if (mk % FRAME == FRAME - 1) modelFrame();
        mk++;
    endfunction

    function automatic void clearEvents();
        n_valid    = 0;
        n_release  = 0;
        first_code = -1;
        last_code  = -1;
        last_at    = -1;
    endfunction

    task automatic applyStimulus(input int n);
        logic [ROWS-1:0] exp_row;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            exp_row = '1;
            exp_row[(mk / SCAN_DIV) % ROWS] = 1'b0;
            checkOutput("key_valid", evt.key_valid, exp_valid);
            checkOutput("key_release", evt.key_release, exp_release);
            checkOutput("key_down", evt.key_down, m_held);
            checkOutput("key_code", evt.key_code, m_code);
            checkOutput("row_n", row_n, exp_row);
            if (evt.key_valid === 1'b1) begin
                if (n_valid == 0) first_code = evt.key_code;
                n_valid++;
                last_code = evt.key_code;
                last_at   = mk;
            end
            if (evt.key_release === 1'b1) n_release++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_row_n"}, row_n, 4'b1110);
        checkOutput({tag, "_code"}, evt.key_code, 0);
        checkOutput({tag, "_valid"}, evt.key_valid, 0);
        checkOutput({tag, "_release"}, evt.key_release, 0);
        checkOutput({tag, "_down"}, evt.key_down, 0);
    endtask

    initial begin
        int press_at, hold, pick;
        bit lat_ok;

        modelReset();
        clearEvents();
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst_n = 1'b1;

        // Idle scan: rows walk, no events.
        applyStimulus(200);
        checkOutput("idle_valids", n_valid, 0);
        checkOutput("idle_releases", n_release, 0);

        // Key 9 pressed at a known phase, then released.
        while (mk % FRAME != 9) applyStimulus(1);
        keys     = 16'd1 << 9;
        press_at = mk;
        clearEvents();
        applyStimulus(60);
        lat_ok = (last_at - press_at >= 35) && (last_at - press_at <= 51);
        checkOutput("press9_valids", n_valid, 1);
        checkOutput("press9_code", last_code, 9);
        checkOutput("press9_latency", lat_ok, 1);
        keys = '0;
        clearEvents();
        applyStimulus(60);
        checkOutput("rel9_releases", n_release, 1);
        checkOutput("rel9_valids", n_valid, 0);
        checkOutput("rel9_code_kept", evt.key_code, 9);

        // Key 5 bouncing with a 20-cycle period, then held steady.
        while (mk % SCAN_DIV != 3) applyStimulus(1);
        clearEvents();
        for (int j = 0; j < 10; j++) begin
            keys = (j % 2 == 0) ? (16'd1 << 5) : 16'd0;
            applyStimulus(10);
        end
        checkOutput("bounce_quiet", n_valid + n_release, 0);
        keys = 16'd1 << 5;
        applyStimulus(60);
        checkOutput("bounce_valids", n_valid, 1);
        checkOutput("bounce_code", last_code, 5);
        keys = '0;
        applyStimulus(60);

        // Slide from key 3 to key 12 without a gap.
        clearEvents();
        keys = 16'd1 << 3;
        applyStimulus(60);
        keys = 16'd1 << 12;
        applyStimulus(60);
        checkOutput("slide_valids", n_valid, 2);
        checkOutput("slide_first", first_code, 3);
        checkOutput("slide_last", last_code, 12);
        checkOutput("slide_releases", n_release, 0);
        keys = '0;
        applyStimulus(60);

        // Chord of keys 0 and 15.
        clearEvents();
        keys = 16'h8001;
        applyStimulus(80);
        checkOutput("chord_valids", n_valid, CHORD_VALIDS);
        checkOutput("chord_code", evt.key_code, CHORD_CODE);
        keys = '0;
        applyStimulus(60);

        // Reset mid-frame with key 7 held.
        keys = 16'd1 << 7;
        applyStimulus(60);
        checkOutput("pre_reset_down", evt.key_down, 1);
        applyStimulus(5);
        #1 rst_n = 1'b0;
        #1 checkResetValues("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        clearEvents();
        applyStimulus(60);
        checkOutput("postreset_valids", n_valid, 1);
        checkOutput("postreset_code", last_code, 7);
        keys = '0;
        applyStimulus(60);

        // Random contact sets and hold times against the reference model.
        for (int it = 0; it < 40; it++) begin
            pick = $urandom_range(0, 9);
            if (pick < 3)      keys = '0;
            else if (pick < 8) keys = 16'd1 << $urandom_range(0, KEYS - 1);
            else               keys = (16'd1 << $urandom_range(0, KEYS - 1)) | (16'd1 << $urandom_range(0, KEYS - 1));
            hold = $urandom_range(4, 70);
            applyStimulus(hold);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Time-multiplexed input scanner for the piano key matrix: drives one active-low row at a time, samples the active-low column lines, debounces the result and reports key press/release events with a key code. It is the input-side counterpart of the display multiplexing strobe. Where the display strobe alternates outputs on a fixed tick, this block walks the matrix rows on a fixed tick and reads the columns back. Outputs feed the tone generator and the display logic directly.

## Interface
- ROWS, 4, number of matrix rows driven (2..8)
- COLS, 4, number of column inputs sampled (2..8)
- SCAN_DIV, 50000, clk cycles per row slot (1 ms at 50 MHz); must be ≥ 4
- DEBOUNCE, 4, consecutive identical frames required before a result is accepted (1..15)
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- row_n  output  ROWS  one-hot-low row drive; exactly one bit low at all times
- col_n  input  COLS  column sense, active-low (external pull-ups); asynchronous to clk
- key_code  output  $clog2(ROWS*COLS)  code of current/last key = row*COLS + col
- key_valid  output  1  one-cycle pulse: new key accepted, key_code updated same cycle
- key_release  output  1  one-cycle pulse: held key released
- key_down  output  1  level: a debounced key is currently held

## Operation
- col_n passes through a 2-flop synchronizer before any use.
- Tick counter runs 0..SCAN_DIV-1 and wraps; the wrap cycle is the slot-end tick.
- At slot-end: synchronized columns are sampled into the frame buffer for the current row, then row_n rotates to the next row (ROWS-1 wraps to 0). Sampling at slot end gives a full slot of settling.
- After the slot-end of row ROWS-1 (frame end), the frame is classified:
  - zero pressed bits -> candidate NONE
  - exactly one pressed bit -> candidate = its code
  - two or more -> see Configuration
- Debounce: candidate equal to previous frame's candidate increments match count (saturating at DEBOUNCE); otherwise count resets to 1. Result becomes stable when count reaches DEBOUNCE. Stable result acts only on the frame where count first reaches DEBOUNCE.
- FSM, states IDLE and HELD:
  - IDLE + stable key K -> HELD; key_code<=K, key_valid pulse, key_down=1
  - HELD + stable NONE -> IDLE; key_release pulse, key_down=0, key_code retained
  - HELD + stable key K≠key_code -> stay HELD; key_code<=K, key_valid pulse, no key_release
  - stable result equal to current state: no event
- key_valid and key_release never assert in the same cycle.

## Timing
- Reset values: row_n = all ones except bit 0 low; key_code=0; key_valid=0; key_release=0; key_down=0; FSM=IDLE; tick, row index, frame buffer, match count cleared; previous candidate = NONE.
- Reset is honoured mid-scan or mid-debounce with no partial event emitted; first full frame completes ROWS*SCAN_DIV cycles after rst_n release.
- Events register one cycle after the frame-end slot-end cycle.
- Press latency, stable contact: between (DEBOUNCE-1)*ROWS*SCAN_DIV+3 and DEBOUNCE*ROWS*SCAN_DIV+3 cycles (2 sync + 1 register).
- Release latency: same bounds.
- Contact bouncing within one frame only affects that frame's sample; each bounced frame restarts the match count.

## Configuration
- KEYSCAN_GHOST_REJECT_EN defined: a frame with ≥2 pressed bits is discarded; candidate and match count are left unchanged, so multi-key chords and ghosting cause no event and do not reset debounce.
- Undefined: a multi-key frame yields the lowest pressed code as candidate (row-major), processed normally.

## Test plan
Parameters for bench: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles).
- Reset, no keys: row_n walks 1110→1101→1011→0111 every 4 cycles; no key_valid/key_release for 200 cycles; key_down=0.
- Hold key row 2 col 1 (col_n[1] low while row_n[2] low): one key_valid with key_code=9, key_down=1, within 35–51 cycles of press; release -> one key_release, key_code stays 9.
- Bounce: toggle key 5 contact every 10 cycles for 100 cycles, then hold steady: no event during bounce, exactly one key_valid (code 5) after 3 clean frames.
- Slide from key 3 to key 12 without gap: key_valid code 3, then key_valid code 12, no key_release between.
- Keys 0 and 15 held together: with KEYSCAN_GHOST_REJECT_EN no event; without it key_valid code 0.
- Assert rst_n low mid-frame while key 7 held and key_down=1: all outputs return to reset values within the same cycle; after release of reset, key_valid code 7 reappears after debounce.
